// File: rtl/trafficlight_monitor.sv
// Receive-side checker for the four-way traffic light controller: decodes the light
// codes into phase S0..S17 and flags conflict, sequence and dwell-time violations.
module trafficlight_monitor #(
  parameter int ERR_CNT_W    = 8,
  parameter bit CHECK_TIMING = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           HighwayTL1,
  input  logic [1:0]           HighwayTL2,
  input  logic [1:0]           FARMTL1,
  input  logic [1:0]           FARMTL2,
  input  logic                 GO,
  output logic [4:0]           phase,
  output logic                 locked,
  output logic                 err_conflict,
  output logic                 err_seq,
  output logic                 err_timing,
  output logic                 cycle_done,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [1:0] C_G  = 2'b00;
  localparam logic [1:0] C_Y  = 2'b01;
  localparam logic [1:0] C_R  = 2'b10;
  localparam logic [1:0] C_RY = 2'b11;
  localparam logic [7:0] ALL_RED = {C_R, C_R, C_R, C_R};

  typedef enum logic [1:0] {TRACK, HUNT, ARM} state_t;

  function automatic logic [7:0] pattern(input logic [4:0] k);
    case (k)
      5'd1:    pattern = {C_RY, C_RY, C_R,  C_R};
      5'd2:    pattern = {C_G,  C_G,  C_R,  C_R};
      5'd3:    pattern = {C_G,  C_Y,  C_R,  C_R};
      5'd4:    pattern = {C_G,  C_R,  C_R,  C_R};
      5'd5:    pattern = {C_Y,  C_R,  C_R,  C_R};
      5'd7:    pattern = {C_R,  C_R,  C_RY, C_RY};
      5'd8:    pattern = {C_R,  C_R,  C_G,  C_G};
      5'd9:    pattern = {C_R,  C_R,  C_G,  C_Y};
      5'd10:   pattern = {C_R,  C_R,  C_G,  C_R};
      5'd11:   pattern = {C_R,  C_R,  C_Y,  C_RY};
      5'd12:   pattern = {C_R,  C_R,  C_R,  C_G};
      5'd13:   pattern = {C_R,  C_R,  C_R,  C_Y};
      5'd15:   pattern = {C_R,  C_RY, C_R,  C_R};
      5'd16:   pattern = {C_R,  C_G,  C_R,  C_R};
      5'd17:   pattern = {C_R,  C_Y,  C_R,  C_R};
      default: pattern = ALL_RED;
    endcase
  endfunction

  function automatic logic [5:0] duration(input logic [4:0] k);
    case (k)
      5'd2:                      duration = 6'd30;
      5'd4, 5'd12:               duration = 6'd10;
      5'd8, 5'd16:               duration = 6'd15;
      5'd10:                     duration = 6'd5;
      5'd17:                     duration = 6'd3;
      5'd0, 5'd6, 5'd14:         duration = 6'd1;
      default:                   duration = 6'd2;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [4:0]             phase_q, phase_d;
  logic                   locked_q, locked_d;
  logic [5:0]             dwell_q, dwell_d;
  logic                   first_s0_q, first_s0_d;
  logic                   go_prev_q, go_prev_d;
  logic                   err_conflict_q, err_conflict_d;
  logic                   err_seq_q, err_seq_d;
  logic                   err_timing_q, err_timing_d;
  logic                   cycle_done_q, cycle_done_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [7:0]             sample;
  logic [4:0]             next_phase;
  logic [5:0]             req_dwell;
  logic [1:0]             err_inc;
  logic [ERR_CNT_W:0]     err_sum;

  always_comb begin
    sample     = {HighwayTL1, HighwayTL2, FARMTL1, FARMTL2};
    next_phase = (phase_q == 5'd17) ? 5'd0 : phase_q + 5'd1;
    req_dwell  = first_s0_q ? 6'd1 : duration(phase_q) - 6'd1;

    state_d        = state_q;
    phase_d        = phase_q;
    dwell_d        = dwell_q;
    first_s0_d     = first_s0_q;
    go_prev_d      = GO;
    err_seq_d      = 1'b0;
    err_timing_d   = 1'b0;
    cycle_done_d   = 1'b0;
    // G and Y both have bit 1 clear: any highway go-ish light against any farm go-ish light
    err_conflict_d = (!HighwayTL1[1] || !HighwayTL2[1]) && (!FARMTL1[1] || !FARMTL2[1]);

    case (state_q)
      TRACK: begin
        if (sample == pattern(phase_q)) begin
          // Adding the previous sample's GO leaves the last sample of the phase uncounted
          dwell_d = (dwell_q == 6'd63) ? 6'd63 : dwell_q + {5'd0, go_prev_q};
        end else if (sample == pattern(next_phase)) begin
          phase_d      = next_phase;
          dwell_d      = 6'd0;
          first_s0_d   = 1'b0;
          err_timing_d = CHECK_TIMING && ((dwell_q == 6'd63) || (dwell_q != req_dwell));
          cycle_done_d = (phase_q == 5'd17);
        end else begin
          err_seq_d = 1'b1;
          state_d   = HUNT;
        end
      end
      HUNT: begin
        if (sample == ALL_RED) state_d = ARM;
      end
      ARM: begin
        if (sample == pattern(5'd1)) begin
          state_d    = TRACK;
          phase_d    = 5'd1;
          dwell_d    = 6'd0;
          first_s0_d = 1'b0;
        end else if (sample != ALL_RED) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    locked_d  = (state_d == TRACK);
    err_inc   = {1'b0, err_conflict_d} + {1'b0, err_seq_d} + {1'b0, err_timing_d};
    err_sum   = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(err_inc);
    err_cnt_d = err_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= TRACK;
      phase_q        <= 5'd0;
      locked_q       <= 1'b1;
      dwell_q        <= 6'd0;
      first_s0_q     <= 1'b1;
      go_prev_q      <= 1'b0;
      err_conflict_q <= 1'b0;
      err_seq_q      <= 1'b0;
      err_timing_q   <= 1'b0;
      cycle_done_q   <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      locked_q       <= locked_d;
      dwell_q        <= dwell_d;
      first_s0_q     <= first_s0_d;
      go_prev_q      <= go_prev_d;
      err_conflict_q <= err_conflict_d;
      err_seq_q      <= err_seq_d;
      err_timing_q   <= err_timing_d;
      cycle_done_q   <= cycle_done_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign phase        = phase_q;
  assign locked       = locked_q;
  assign err_conflict = err_conflict_q;
  assign err_seq      = err_seq_q;
  assign err_timing   = err_timing_q;
  assign cycle_done   = cycle_done_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Directed bench for trafficlight_monitor: a reference light controller drives legal
// sequences, with injected conflicts, short dwells, illegal floods and resets.
module tb_trafficlight_monitor;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] hw1, hw2, f1, f2;
  logic       go;
  logic [4:0] phase;
  logic       locked, err_conflict, err_seq, err_timing, cycle_done;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int ctl_st, ctl_cnt, dur4;
  bit ctl_first;

  trafficlight_monitor #(.ERR_CNT_W(8), .CHECK_TIMING(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .HighwayTL1(hw1), .HighwayTL2(hw2), .FARMTL1(f1), .FARMTL2(f2), .GO(go),
    .phase(phase), .locked(locked), .err_conflict(err_conflict), .err_seq(err_seq),
    .err_timing(err_timing), .cycle_done(cycle_done), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Golden light table {HW1,HW2,F1,F2}; G=00 Y=01 R=10 RY=11
  function automatic logic [7:0] pat(input int k);
    case (k)
      1:  return 8'b11_11_10_10;
      2:  return 8'b00_00_10_10;
      3:  return 8'b00_01_10_10;
      4:  return 8'b00_10_10_10;
      5:  return 8'b01_10_10_10;
      7:  return 8'b10_10_11_11;
      8:  return 8'b10_10_00_00;
      9:  return 8'b10_10_00_01;
      10: return 8'b10_10_00_10;
      11: return 8'b10_10_01_11;
      12: return 8'b10_10_10_00;
      13: return 8'b10_10_10_01;
      15: return 8'b10_11_10_10;
      16: return 8'b10_00_10_10;
      17: return 8'b10_01_10_10;
      default: return 8'b10_10_10_10;
    endcase
  endfunction

  function automatic int dur_of(input int k, input bit first, input int d4);
    int d[18] = '{1, 2, 30, 2, 10, 2, 1, 2, 15, 2, 5, 2, 10, 2, 1, 2, 15, 3};
    if (k == 0 && first) return 2;
    if (k == 4) return d4;
    return d[k];
  endfunction

  task automatic ctl_reset();
    ctl_st = 0; ctl_cnt = 0; ctl_first = 1'b1;
  endtask

  // One controller sample: present lights, clock it in, then advance the controller
  task automatic ctl_cycle(input bit g, input bit corrupt, output int sampled);
    sampled = ctl_st;
    {hw1, hw2, f1, f2} = corrupt ? 8'b00_10_00_00 : pat(ctl_st);
    go = g;
    @(posedge CLK); #1;
    if (g) begin
      ctl_cnt++;
      if (ctl_cnt >= dur_of(ctl_st, ctl_first, dur4)) begin
        ctl_st = (ctl_st + 1) % 18; ctl_cnt = 0; ctl_first = 1'b0;
      end
    end
  endtask

  task automatic raw_cycle(input logic [7:0] p, input bit g);
    {hw1, hw2, f1, f2} = p;
    go = g;
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, prev_s, errs, cd, s0n, s2n;
    bit found;
    dur4 = 10;
    ctl_reset();
    RST = 1'b0;
    {hw1, hw2, f1, f2} = pat(0);
    go = 1'b1;
    #12;
    check_eq("rst_phase", phase, 0);
    check_eq("rst_locked", locked, 1);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_pulses", {err_conflict, err_seq, err_timing, cycle_done}, 0);
    @(posedge CLK); #1;
    RST = 1'b1;

    // Test 1: three full cycles at GO=1
    prev_s = -1; errs = 0; cd = 0; s0n = 0; s2n = 0;
    for (int i = 0; i < 323; i++) begin
      ctl_cycle(1'b1, 1'b0, s);
      check_eq("t1_phase", phase, s);
      check_eq("t1_cycle_done", cycle_done, (prev_s == 17 && s == 0) ? 1 : 0);
      errs += int'(err_conflict) + int'(err_seq) + int'(err_timing) + int'(!locked);
      cd += int'(cycle_done);
      if (phase == 5'd0) s0n++;
      if (phase == 5'd2) s2n++;
      prev_s = s;
    end
    check_eq("t1_errors", errs, 0);
    check_eq("t1_cycle_done_cnt", cd, 3);
    check_eq("t1_s0_samples", s0n, 5);
    check_eq("t1_s2_samples", s2n, 90);
    check_eq("t1_err_cnt", err_cnt, 0);

    // Test 2: GO toggling every 20 samples
    errs = 0;
    for (int i = 0; i < 214; i++) begin
      ctl_cycle(((i / 20) % 2) == 0, 1'b0, s);
      check_eq("t2_phase", phase, s);
      errs += int'(err_timing) + int'(err_seq) + int'(!locked);
    end
    check_eq("t2_errors", errs, 0);
    check_eq("t2_err_cnt", err_cnt, 0);

    // Test 3: conflict injected during S8, then relock at S1
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (ctl_st == 8 && ctl_cnt == 5) found = 1'b1;
      else ctl_cycle(1'b1, 1'b0, s);
    end
    check_eq("t3_reach_s8", found, 1);
    ctl_cycle(1'b1, 1'b1, s);
    check_eq("t3_conflict", err_conflict, 1);
    check_eq("t3_seq", err_seq, 1);
    check_eq("t3_unlocked", locked, 0);
    check_eq("t3_err_cnt", err_cnt, 2);
    ctl_cycle(1'b1, 1'b0, s);
    check_eq("t3_pulses_end", {err_conflict, err_seq}, 0);
    check_eq("t3_still_hunting", locked, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      ctl_cycle(1'b1, 1'b0, s);
      if (locked) found = 1'b1;
    end
    check_eq("t3_relock", found, 1);
    check_eq("t3_relock_state", s, 1);
    check_eq("t3_relock_phase", phase, 1);
    check_eq("t3_err_cnt_after", err_cnt, 2);

    // Test 4: S4 left after 9 GO-high samples
    dur4 = 9;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      ctl_cycle(1'b1, 1'b0, s);
      if (s == 5) found = 1'b1;
      else check_eq("t4_no_early_timing", err_timing, 0);
    end
    dur4 = 10;
    check_eq("t4_reach_s5", found, 1);
    check_eq("t4_timing", err_timing, 1);
    check_eq("t4_phase", phase, 5);
    check_eq("t4_locked", locked, 1);
    check_eq("t4_err_cnt", err_cnt, 3);
    ctl_cycle(1'b1, 1'b0, s);
    check_eq("t4_timing_pulse", err_timing, 0);

    // Test 5: flood of conflicting patterns saturates err_cnt
    for (int n = 1; n <= 300; n++) begin
      raw_cycle(8'b00_00_00_00, 1'b1);
      if (n == 1) begin
        check_eq("t5_first_seq", err_seq, 1);
        check_eq("t5_first_cnt", err_cnt, 5);
      end
      if (n == 2) check_eq("t5_no_seq_in_hunt", err_seq, 0);
      if (n == 100) check_eq("t5_cnt_100", err_cnt, 104);
      if (n == 250) check_eq("t5_cnt_250", err_cnt, 254);
    end
    check_eq("t5_saturated", err_cnt, 255);
    check_eq("t5_conflict", err_conflict, 1);
    check_eq("t5_unlocked", locked, 0);

    // Test 6: reset out of HUNT, then reset again mid-S12
    RST = 1'b0;
    #2;
    check_eq("t6_rst_cnt", err_cnt, 0);
    check_eq("t6_rst_locked", locked, 1);
    check_eq("t6_rst_phase", phase, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    ctl_reset();
    errs = 0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      ctl_cycle(1'b1, 1'b0, s);
      check_eq("t6_phase", phase, s);
      errs += int'(err_conflict) + int'(err_seq) + int'(err_timing);
      if (s == 12 && ctl_cnt == 4) found = 1'b1;
    end
    check_eq("t6_reach_s12", found, 1);
    check_eq("t6_s12_phase", phase, 12);
    #2 RST = 1'b0;
    #1;
    check_eq("t6_async_phase", phase, 0);
    check_eq("t6_async_locked", locked, 1);
    check_eq("t6_async_pulses", {err_conflict, err_seq, err_timing, cycle_done}, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    ctl_reset();
    for (int i = 0; i < 120; i++) begin
      ctl_cycle(1'b1, 1'b0, s);
      check_eq("t6_retrack_phase", phase, s);
      errs += int'(err_conflict) + int'(err_seq) + int'(err_timing) + int'(!locked);
    end
    check_eq("t6_errors", errs, 0);
    check_eq("t6_err_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
